// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding and BCD adjust constants for bin2bcd_seq
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;
endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: add 3 to one BCD digit when it is 5 or more, ahead of the doubling shift
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter; BIN2BCD_BLANK_EN adds the leading-zero blank mask port
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]         blank
`endif
);
  localparam int SW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BIN_W-1:0] sr, sr_n;
  logic [SW-1:0] sc, adj, sc_n;
  logic ovf_acc, ovf_n, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(sc[DIGIT_W*i +: DIGIT_W]), .q(adj[DIGIT_W*i +: DIGIT_W]));
  end
  assign {sc_n, sr_n} = {adj[SW-2:0], sr, 1'b0};
  assign ovf_n = ovf_acc | adj[SW-1];
  assign last = (state == SHIFT) && (cnt == CW'(1));
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_n;
  // a digit is blanked only when it and every digit above it are zero; units never blank
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_units
      assign blank_n[i] = 1'b0;
    end else begin : g_upper
      assign blank_n[i] = ~|sc_n[SW-1:DIGIT_W*i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) blank <= '0;
    else if (last) blank <= blank_n;
  end
`endif
  // results are captured on the final shift so they are already valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      sc <= '0;
      ovf_acc <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sr <= bin;
        sc <= '0;
        ovf_acc <= 1'b0;
        cnt <= CW'(BIN_W);
      end else if (state == SHIFT) begin
        sr <= sr_n;
        sc <= sc_n;
        ovf_acc <= ovf_n;
        cnt <= cnt - CW'(1);
      end
      if (last) begin
        bcd <= sc_n;
        ovf <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq at 16b/5 digits and 8b/2 digits
module tb_bin2bcd_seq;
  typedef struct {
    logic [19:0] b;
    logic        o;
    logic [4:0]  bl;
  } exp_t;
  logic clk = 0, rst = 1;
  logic start16 = 0, start8 = 0;
  logic [15:0] bin16 = 0;
  logic [7:0] bin8 = 0;
  logic busy16, done16, ovf16, busy8, done8, ovf8;
  logic [19:0] bcd16;
  logic [7:0] bcd8;
`ifdef BIN2BCD_BLANK_EN
  logic [4:0] blank16;
  logic [1:0] blank8;
`endif
  int checks = 0, failures = 0;
  exp_t q16[$], q8[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) d16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16), .busy(busy16), .done(done16),
    .bcd(bcd16), .ovf(ovf16)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank16)
`endif
  );
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) d8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busy8), .done(done8),
    .bcd(bcd8), .ovf(ovf8)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank8)
`endif
  );

  always @(negedge clk) begin
    if (!rst && done16) begin
      checks++;
      if (q16.size() == 0) begin
        failures++;
        $display("FAIL d16_unexpected_done got bcd=%h ovf=%b required no done", bcd16, ovf16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        if (bcd16 !== e.b || ovf16 !== e.o
`ifdef BIN2BCD_BLANK_EN
            || blank16 !== e.bl
`endif
           ) begin
          failures++;
          $display("FAIL d16_result got bcd=%h ovf=%b required bcd=%h ovf=%b blank=%b", bcd16, ovf16, e.b, e.o, e.bl);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL d8_unexpected_done got bcd=%h ovf=%b required no done", bcd8, ovf8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (bcd8 !== e.b[7:0] || ovf8 !== e.o
`ifdef BIN2BCD_BLANK_EN
            || blank8 !== e.bl[1:0]
`endif
           ) begin
          failures++;
          $display("FAIL d8_result got bcd=%h ovf=%b required bcd=%h ovf=%b blank=%b", bcd8, ovf8, e.b[7:0], e.o, e.bl[1:0]);
        end
      end
    end
  end

  task automatic chk(input string n, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", n, got, req);
    end
  endtask

  task automatic wait_idle(input bit w8);
    for (int k = 0; k < 40 && (w8 ? busy8 : busy16); k++) @(negedge clk);
    if (w8 ? busy8 : busy16) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got busy=1 required busy=0 within 40 cycles", w8 ? "d8" : "d16");
    end
  endtask

  task automatic conv(input bit w8, input logic [15:0] v, input logic [19:0] eb, input logic eo, input logic [4:0] ebl);
    exp_t e;
    e.b = eb; e.o = eo; e.bl = ebl;
    wait_idle(w8);
    if (w8) begin
      q8.push_back(e); start8 = 1; bin8 = v[7:0];
    end else begin
      q16.push_back(e); start16 = 1; bin16 = v;
    end
    @(negedge clk);
    start8 = 0; start16 = 0;
    wait_idle(w8);
  endtask

  function automatic exp_t model(input int v, input int nd);
    exp_t e;
    int p = 1, r;
    for (int i = 0; i < nd; i++) p *= 10;
    r = v % p;
    e.b = '0; e.bl = '0;
    e.o = v >= p;
    for (int i = 0, q = 1; i < nd; i++, q *= 10) begin
      e.b[4*i +: 4] = 4'((r / q) % 10);
      e.bl[i] = (i > 0) && (r / q == 0);
    end
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit bz;
    exp_t e;
    logic [15:0] v;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy16, 0);
    chk("reset_done", done16, 0);
    chk("reset_bcd", int'(bcd16), 0);
    chk("reset_ovf", ovf16, 0);
    rst = 0;
    @(negedge clk);
    e.b = 20'h00000; e.o = 0; e.bl = 5'b11110;
    q16.push_back(e);
    start16 = 1; bin16 = 16'd0;
    @(negedge clk);
    start16 = 0;
    lat = 1; bz = 1;
    while (!done16 && lat < 40) begin
      bz &= busy16;
      @(negedge clk);
      lat++;
    end
    bz &= busy16;
    chk("latency", lat, 17);
    chk("busy_window", int'(bz), 1);
    @(negedge clk);
    chk("busy_drop", busy16, 0);
    conv(0, 16'd65535, 20'h65535, 0, 5'b00000);
    conv(0, 16'd1234, 20'h01234, 0, 5'b10000);
    conv(0, 16'd10000, 20'h10000, 0, 5'b00000);
    conv(0, 16'd9999, 20'h09999, 0, 5'b10000);
    // start held high while busy with bin moving every cycle
    e.b = 20'h00100; e.o = 0; e.bl = 5'b11000; q16.push_back(e);
    e.b = 20'h00118; q16.push_back(e);
    start16 = 1; bin16 = 16'd100;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      bin16 = 16'(100 + k);
    end
    @(negedge clk);
    start16 = 0;
    chk("reaccept_busy", busy16, 1);
    wait_idle(0);
    chk("held_start_queue", q16.size(), 0);
    e.b = 20'h00000; e.o = 0; e.bl = 5'b11110;
    start16 = 1; bin16 = 16'd4321;
    @(negedge clk);
    start16 = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy16, 0);
    chk("abort_bcd", int'(bcd16), 0);
    chk("abort_ovf", ovf16, 0);
    repeat (20) @(negedge clk);
    conv(0, 16'd9, 20'h00009, 0, 5'b11110);
    conv(1, 16'd255, 20'h00055, 1, 5'b00000);
    conv(1, 16'd99, 20'h00099, 0, 5'b00000);
    conv(1, 16'd0, 20'h00000, 0, 5'b00010);
    conv(1, 16'd100, 20'h00000, 1, 5'b00010);
    conv(1, 16'd7, 20'h00007, 0, 5'b00010);
    for (int n = 0; n < 150; n++) begin
      v = 16'($urandom);
      e = model(int'(v), 5);
      conv(0, v, e.b, e.o, e.bl);
    end
    for (int n = 0; n < 100; n++) begin
      v = 16'($urandom_range(255));
      e = model(int'(v), 2);
      conv(1, v, e.b, e.o, e.bl);
    end
    repeat (3) @(negedge clk);
    chk("d16_queue_empty", q16.size(), 0);
    chk("d8_queue_empty", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
